// File: rtl/sccomp_if.sv
// Fetch and data-memory buses between the pipelined core and its memories.
// The core is the master; the ROM and RAM each implement their half.
interface sccomp_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  modport master (
    output pc, dm_addr, dm_wdata, dm_we,
    input  instr, dm_rdata
  );
  modport im_slave (
    input  pc,
    output instr
  );
  modport dm_slave (
    input  dm_addr, dm_wdata, dm_we,
    output dm_rdata
  );
endinterface

// File: rtl/sccomp.sv
// Simulation computer: 5-stage RV32I-subset core with word ROM and RAM.
// Hazards: EX/MEM and MEM/WB forwarding, 1-cycle load-use stall, EX redirect.
package sccomp_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [1:0] {
    A_RS1, A_PC, A_ZERO
  } a_sel_t;

  typedef struct packed {
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       b_imm;
    a_sel_t     a_sel;
    alu_op_t    alu_op;
    logic       branch;
    logic [2:0] br_f3;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    ctrl_t       ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam if_id_t IF_ID_NOP = '{pc: 32'd0, instr: NOP_INSTR};
endpackage

module sc_rf (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] rf [0:31];
  logic        wr;

  assign wr = we && (wa != 5'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr) begin
      rf[wa] <= wd;
    end
  end

  // WB write is visible to the same-cycle ID read
  always_comb begin
    rd1 = rf[ra1];
    rd2 = rf[ra2];
    if (wr && wa == ra1) rd1 = wd;
    if (wr && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end
endmodule

module sc_im #(
  parameter int IM_DEPTH = 128
) (
  sccomp_if.im_slave bus
);
  localparam int AW = $clog2(IM_DEPTH);

  logic [31:0] ROM [0:IM_DEPTH-1];
  logic        unused_pc;

  assign bus.instr = ROM[bus.pc[AW+1:2]];
  assign unused_pc = ^{bus.pc[31:AW+2], bus.pc[1:0]};
endmodule

module sc_dm #(
  parameter int DM_DEPTH = 128
) (
  input logic        clk,
  input logic        rstn,
  sccomp_if.dm_slave bus
);
  localparam int AW = $clog2(DM_DEPTH);

  logic [31:0]   dmem [0:DM_DEPTH-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx = bus.dm_addr[AW+1:2];
  assign unused_addr = ^{bus.dm_addr[31:AW+2], bus.dm_addr[1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DM_DEPTH; i++) dmem[i] <= '0;
    end else if (bus.dm_we) begin
      dmem[idx] <= bus.dm_wdata;
    end
  end

  assign bus.dm_rdata = dmem[idx];
endmodule

module sc_cpu (
  input logic      clk,
  input logic      rstn,
  sccomp_if.master bus
);
  import sccomp_pkg::*;

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, id_dec;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic        stall, redirect;
  logic [31:0] target;

  function automatic alu_op_t alu_dec(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign bus.pc = pc_q;

  // ---- ID ----
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rf_rd1, rf_rd2;
  logic        is_r, is_i, is_lui, is_auipc;
  logic        is_lw, is_sw, is_br, is_jal, is_jalr;
  logic        use1, use2;
  ctrl_t       c;
  logic [31:0] imm;

  assign ins = if_id_q.instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'd0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  assign is_r     = opc == 7'b0110011;
  assign is_i     = opc == 7'b0010011;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_lw    = opc == 7'b0000011 && f3 == 3'b010;
  assign is_sw    = opc == 7'b0100011 && f3 == 3'b010;
  assign is_br    = opc == 7'b1100011 &&
                    (f3 == 3'b000 || f3 == 3'b001 ||
                     f3 == 3'b100 || f3 == 3'b101);
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111 && f3 == 3'b000;

  always_comb begin
    c    = '0;
    imm  = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    unique case (1'b1)
      is_r: begin
        c.reg_we = 1'b1;
        c.alu_op = alu_dec(f3, ins[30]);
        use1 = 1'b1;
        use2 = 1'b1;
      end
      is_i: begin
        c.reg_we = 1'b1;
        c.b_imm  = 1'b1;
        c.alu_op = alu_dec(f3, f3 == 3'b101 && ins[30]);
        imm  = imm_i;
        use1 = 1'b1;
      end
      is_lui: begin
        c.reg_we = 1'b1;
        c.b_imm  = 1'b1;
        c.a_sel  = A_ZERO;
        imm = imm_u;
      end
      is_auipc: begin
        c.reg_we = 1'b1;
        c.b_imm  = 1'b1;
        c.a_sel  = A_PC;
        imm = imm_u;
      end
      is_lw: begin
        c.reg_we = 1'b1;
        c.mem_re = 1'b1;
        c.b_imm  = 1'b1;
        imm  = imm_i;
        use1 = 1'b1;
      end
      is_sw: begin
        c.mem_we = 1'b1;
        c.b_imm  = 1'b1;
        imm  = imm_s;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      is_br: begin
        c.branch = 1'b1;
        c.br_f3  = f3;
        imm  = imm_b;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      is_jal: begin
        c.reg_we = 1'b1;
        c.jal    = 1'b1;
        imm = imm_j;
      end
      is_jalr: begin
        c.reg_we = 1'b1;
        c.jalr   = 1'b1;
        imm  = imm_i;
        use1 = 1'b1;
      end
      default: ;
    endcase
  end

  sc_rf U_RF (
    .clk  (clk),
    .rstn (rstn),
    .ra1  (rs1),
    .ra2  (rs2),
    .we   (mem_wb_q.reg_we),
    .wa   (mem_wb_q.rd),
    .wd   (mem_wb_q.wdata),
    .rd1  (rf_rd1),
    .rd2  (rf_rd2)
  );

  assign id_dec = '{
    pc:   if_id_q.pc,
    rs1:  rs1,
    rs2:  rs2,
    rd:   rd,
    rd1:  rf_rd1,
    rd2:  rf_rd2,
    imm:  imm,
    ctrl: c
  };

  assign stall = id_ex_q.ctrl.mem_re && id_ex_q.rd != 5'd0 &&
                 ((use1 && rs1 == id_ex_q.rd) ||
                  (use2 && rs2 == id_ex_q.rd));

  // ---- EX ----
  logic [31:0] fa, fb, op_a, op_b, alu;
  logic [4:0]  shamt;
  logic        take;
  logic        fwd_m1, fwd_w1, fwd_m2, fwd_w2;

  assign fwd_m1 = ex_mem_q.reg_we && ex_mem_q.rd != 5'd0 &&
                  ex_mem_q.rd == id_ex_q.rs1;
  assign fwd_w1 = mem_wb_q.reg_we && mem_wb_q.rd != 5'd0 &&
                  mem_wb_q.rd == id_ex_q.rs1;
  assign fwd_m2 = ex_mem_q.reg_we && ex_mem_q.rd != 5'd0 &&
                  ex_mem_q.rd == id_ex_q.rs2;
  assign fwd_w2 = mem_wb_q.reg_we && mem_wb_q.rd != 5'd0 &&
                  mem_wb_q.rd == id_ex_q.rs2;

  assign fa = fwd_m1 ? ex_mem_q.res :
              fwd_w1 ? mem_wb_q.wdata : id_ex_q.rd1;
  assign fb = fwd_m2 ? ex_mem_q.res :
              fwd_w2 ? mem_wb_q.wdata : id_ex_q.rd2;

  always_comb begin
    case (id_ex_q.ctrl.a_sel)
      A_PC:    op_a = id_ex_q.pc;
      A_ZERO:  op_a = '0;
      default: op_a = fa;
    endcase
  end

  assign op_b  = id_ex_q.ctrl.b_imm ? id_ex_q.imm : fb;
  assign shamt = op_b[4:0];

  always_comb begin
    case (id_ex_q.ctrl.alu_op)
      ALU_SUB:  alu = op_a - op_b;
      ALU_AND:  alu = op_a & op_b;
      ALU_OR:   alu = op_a | op_b;
      ALU_XOR:  alu = op_a ^ op_b;
      ALU_SLT:  alu = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu = {31'd0, op_a < op_b};
      ALU_SLL:  alu = op_a << shamt;
      ALU_SRL:  alu = op_a >> shamt;
      ALU_SRA:  alu = $signed(op_a) >>> shamt;
      default:  alu = op_a + op_b;
    endcase
  end

  always_comb begin
    case (id_ex_q.ctrl.br_f3)
      3'b000:  take = fa == fb;
      3'b001:  take = fa != fb;
      3'b100:  take = $signed(fa) < $signed(fb);
      3'b101:  take = $signed(fa) >= $signed(fb);
      default: take = 1'b0;
    endcase
  end

  assign redirect = (id_ex_q.ctrl.branch && take) ||
                    id_ex_q.ctrl.jal || id_ex_q.ctrl.jalr;
  assign target = id_ex_q.ctrl.jalr ?
                  ((fa + id_ex_q.imm) & ~32'd1) :
                  id_ex_q.pc + id_ex_q.imm;

  assign ex_mem_d = '{
    res:    (id_ex_q.ctrl.jal || id_ex_q.ctrl.jalr) ?
            id_ex_q.pc + 32'd4 : alu,
    sdata:  fb,
    rd:     id_ex_q.rd,
    reg_we: id_ex_q.ctrl.reg_we,
    mem_re: id_ex_q.ctrl.mem_re,
    mem_we: id_ex_q.ctrl.mem_we
  };

  // ---- MEM ----
  assign bus.dm_addr  = ex_mem_q.res;
  assign bus.dm_wdata = ex_mem_q.sdata;
  assign bus.dm_we    = ex_mem_q.mem_we;

  assign mem_wb_d = '{
    wdata:  ex_mem_q.mem_re ? bus.dm_rdata : ex_mem_q.res,
    rd:     ex_mem_q.rd,
    reg_we: ex_mem_q.reg_we
  };

  // ---- front-end steering: redirect beats stall ----
  always_comb begin
    pc_d    = pc_q + 32'd4;
    if_id_d = '{pc: pc_q, instr: bus.instr};
    id_ex_d = id_dec;
    if (redirect) begin
      pc_d    = target;
      if_id_d = IF_ID_NOP;
      id_ex_d = '0;
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= '0;
      if_id_q  <= IF_ID_NOP;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end
endmodule

module sccomp #(
  parameter int IM_DEPTH = 128,
  parameter int DM_DEPTH = 128
) (
  input logic clk,
  input logic rstn
);
  sccomp_if bus ();

  logic [31:0] PC;
  logic [31:0] instr;
  logic        unused_probe;

  sc_cpu U_SCPU (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  sc_im #(.IM_DEPTH(IM_DEPTH)) U_IM (
    .bus (bus.im_slave)
  );

  sc_dm #(.DM_DEPTH(DM_DEPTH)) U_DM (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.dm_slave)
  );

  // Probe points for benches
  assign PC    = bus.pc;
  assign instr = bus.instr;
  assign unused_probe = ^{PC, instr};
endmodule

// File: tb/tb_sccomp.sv
// Directed program bench for sccomp: loads small programs into the ROM,
// runs a fixed number of cycles and checks register, memory and PC probes.
module tb_sccomp;
  logic clk = 1'b0;
  logic rstn = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sccomp dut (
    .clk  (clk),
    .rstn (rstn)
  );

  sccomp_if mon ();
  assign mon.pc       = dut.PC;
  assign mon.instr    = dut.instr;
  assign mon.dm_addr  = dut.bus.dm_addr;
  assign mon.dm_wdata = dut.bus.dm_wdata;
  assign mon.dm_we    = dut.bus.dm_we;
  assign mon.dm_rdata = dut.bus.dm_rdata;

  typedef struct {
    int          prog;
    bit          is_dm;
    int          idx;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int NPROG = 5;
  localparam int PLEN  = 16;

  logic [31:0] prog [NPROG][PLEN];
  vec_t        vecs [$];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic add(input int p, input bit dm, input int idx,
                     input logic [31:0] exp, input string name);
    vec_t v;
    v.prog  = p;
    v.is_dm = dm;
    v.idx   = idx;
    v.exp   = exp;
    v.name  = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] pc_exp [13];
    logic [31:0] prev, got, acc;
    int stalls;

    for (int p = 0; p < NPROG; p++)
      for (int i = 0; i < PLEN; i++) prog[p][i] = 32'h0;

    // 0: ALU + forwarding
    prog[0][0]  = 32'h00500093; // addi x1,x0,5
    prog[0][1]  = 32'h00308113; // addi x2,x1,3
    prog[0][2]  = 32'h002081B3; // add  x3,x1,x2
    prog[0][3]  = 32'h40110233; // sub  x4,x2,x1
    prog[0][4]  = 32'h0041C2B3; // xor  x5,x3,x4
    prog[0][5]  = 32'h00322333; // slt  x6,x4,x3
    prog[0][6]  = 32'h002093B3; // sll  x7,x1,x2
    prog[0][7]  = 32'h0020E433; // or   x8,x1,x2
    prog[0][8]  = 32'h0011F4B3; // and  x9,x3,x1
    prog[0][9]  = 32'h12345537; // lui  x10,0x12345
    // 1: store, load-use
    prog[1][0]  = 32'h05500293; // addi x5,x0,0x55
    prog[1][1]  = 32'h00502423; // sw   x5,8(x0)
    prog[1][2]  = 32'h00802303; // lw   x6,8(x0)
    prog[1][3]  = 32'h00130393; // addi x7,x6,1
    // 2: branches
    prog[2][0]  = 32'h00100093; // addi x1,x0,1
    prog[2][1]  = 32'h00108463; // beq  x1,x1,+8
    prog[2][2]  = 32'h00900113; // addi x2,x0,9
    prog[2][3]  = 32'h00700193; // addi x3,x0,7
    prog[2][4]  = 32'hFFF00213; // addi x4,x0,-1
    prog[2][5]  = 32'h00024463; // blt  x4,x0,+8
    prog[2][6]  = 32'h00500293; // addi x5,x0,5
    prog[2][7]  = 32'h00421463; // bne  x4,x4,+8
    prog[2][8]  = 32'h00600313; // addi x6,x0,6
    // 3: jumps
    prog[3][0]  = 32'h00000013;
    prog[3][1]  = 32'h00000013;
    prog[3][2]  = 32'h00000013;
    prog[3][3]  = 32'h00000013;
    prog[3][4]  = 32'h00C000EF; // 0x10 jal  x1,+12
    prog[3][5]  = 32'h0000006F; // 0x14 jal  x0,0
    prog[3][6]  = 32'h00300193; // 0x18 addi x3,x0,3
    prog[3][7]  = 32'h00008067; // 0x1C jalr x0,0(x1)
    prog[3][8]  = 32'h00400213; // 0x20 addi x4,x0,4
    // 4: x0, shifts, compares, auipc
    prog[4][0]  = 32'h00500013; // addi x0,x0,5
    prog[4][1]  = 32'hFF800093; // addi x1,x0,-8
    prog[4][2]  = 32'h4010D113; // srai x2,x1,1
    prog[4][3]  = 32'h01C0D193; // srli x3,x1,28
    prog[4][4]  = 32'h0010A293; // slti x5,x1,1
    prog[4][5]  = 32'h00103333; // sltu x6,x0,x1
    prog[4][6]  = 32'h00001397; // 0x18 auipc x7,1

    add(0, 0, 1,  32'd5,          "alu_x1");
    add(0, 0, 2,  32'd8,          "alu_x2");
    add(0, 0, 3,  32'd13,         "alu_x3");
    add(0, 0, 4,  32'd3,          "alu_x4");
    add(0, 0, 5,  32'd14,         "alu_xor");
    add(0, 0, 6,  32'd1,          "alu_slt");
    add(0, 0, 7,  32'h500,        "alu_sll");
    add(0, 0, 8,  32'd13,         "alu_or");
    add(0, 0, 9,  32'd5,          "alu_and");
    add(0, 0, 10, 32'h12345000,   "alu_lui");
    add(1, 1, 2,  32'h55,         "mem_dmem2");
    add(1, 0, 6,  32'h55,         "mem_x6");
    add(1, 0, 7,  32'h56,         "mem_x7");
    add(2, 0, 1,  32'd1,          "br_x1");
    add(2, 0, 2,  32'd0,          "br_flush_x2");
    add(2, 0, 3,  32'd7,          "br_x3");
    add(2, 0, 4,  32'hFFFFFFFF,   "br_x4");
    add(2, 0, 5,  32'd0,          "blt_flush_x5");
    add(2, 0, 6,  32'd6,          "bne_fall_x6");
    add(3, 0, 1,  32'h14,         "jal_link_x1");
    add(3, 0, 3,  32'd0,          "jmp_flush_x3");
    add(3, 0, 4,  32'd0,          "jalr_flush_x4");
    add(4, 0, 0,  32'd0,          "x0_zero");
    add(4, 0, 1,  32'hFFFFFFF8,   "sh_x1");
    add(4, 0, 2,  32'hFFFFFFFC,   "srai_x2");
    add(4, 0, 3,  32'h0000000F,   "srli_x3");
    add(4, 0, 5,  32'd1,          "slti_x5");
    add(4, 0, 6,  32'd1,          "sltu_x6");
    add(4, 0, 7,  32'h1018,       "auipc_x7");

    pc_exp = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
               32'h1C, 32'h20, 32'h24, 32'h14, 32'h18, 32'h1C,
               32'h14};

    for (int p = 0; p < NPROG; p++) begin
      // Reset (also aborts the previous program mid-run)
      #1 rstn = 1'b0;
      for (int i = 0; i < 128; i++)
        dut.U_IM.ROM[i] = (i < PLEN) ? prog[p][i] : 32'h0;
      #20;
      check("rst_pc", mon.pc, 32'h0);
      acc = '0;
      for (int i = 0; i < 32; i++) acc |= dut.U_SCPU.U_RF.rf[i];
      check("rst_rf", acc, 32'h0);
      acc = '0;
      for (int i = 0; i < 128; i++) acc |= dut.U_DM.dmem[i];
      check("rst_dmem", acc, 32'h0);
      check("rst_instr", mon.instr, prog[p][0]);

      @(negedge clk);
      rstn = 1'b1;
      prev   = 32'h0;
      stalls = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(posedge clk);
        #1;
        got = mon.pc;
        if (p == 0 && cyc <= 3)
          check($sformatf("pc_step%0d", cyc), got, 32'(cyc * 4));
        if (p == 3 && cyc <= 13)
          check($sformatf("jmp_pc%0d", cyc), got, pc_exp[cyc-1]);
        if (p == 1 && cyc <= 20 && got == prev) stalls++;
        prev = got;
      end
      if (p == 1) check("load_use_stalls", 32'(stalls), 32'd1);

      foreach (vecs[k]) begin
        if (vecs[k].prog == p) begin
          got = vecs[k].is_dm ? dut.U_DM.dmem[vecs[k].idx]
                              : dut.U_SCPU.U_RF.rf[vecs[k].idx];
          check(vecs[k].name, got, vecs[k].exp);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
